keypad_scanner: RTL and testbench

//   4x4 matrix keypad scanner with debounce. Upstream stage of the tone generator:

---
 rtl/keypad_scanner.sv | 166 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces a single
// keypress on the synchronized rows and holds the last accepted key code.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  logic [3:0]       row_meta_r;
  logic [3:0]       rows_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;
  state_t           state_r;
  logic [1:0]       col_idx_r;
  logic [1:0]       row_idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic             any_low_s;
  logic [1:0]       low_row_s;
  logic             sel_row_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [1:0]       col_next_s;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] drv;
    case (idx)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = 4'b1110;
    endcase
    return drv;
  endfunction

  // Two-stage synchronizer for the asynchronous row lines; idle rows read high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_r <= 4'hF;
      rows_r     <= 4'hF;
    end else begin
      row_meta_r <= row_in;
      rows_r     <= row_meta_r;
    end
  end

  // Scan tick divider: one-clock tick at the end of each SCAN_DIV period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Row priority encode, selected-row lookup and counter increments.
  always_comb begin
    tick_s     = (div_cnt_r == DIV_MAX);
    any_low_s  = (rows_r != 4'hF);
    sel_row_s  = rows_r[row_idx_r];
    cnt_inc_s  = cnt_r + CNT_W'(1);
    col_next_s = col_idx_r + 2'd1;
    if (!rows_r[0]) begin
      low_row_s = 2'd0;
    end else if (!rows_r[1]) begin
      low_row_s = 2'd1;
    end else if (!rows_r[2]) begin
      low_row_s = 2'd2;
    end else begin
      low_row_s = 2'd3;
    end
  end

  // Scan / debounce / held state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_SCAN;
      col_idx_r <= 2'd0;
      row_idx_r <= 2'd0;
      cnt_r     <= {CNT_W{1'b0}};
      col_out   <= 4'b1110;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick_s) begin
        case (state_r)
          ST_SCAN: begin
            if (any_low_s) begin
              row_idx_r <= low_row_s;
              // A single-tick debounce accepts on the detecting tick itself.
              if (DEBOUNCE_TICKS == 1) begin
                key_code  <= {low_row_s, col_idx_r};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt_r     <= {CNT_W{1'b0}};
                state_r   <= ST_HELD;
              end else begin
                cnt_r   <= CNT_W'(1);
                state_r <= ST_DEBOUNCE;
              end
            end else begin
              col_idx_r <= col_next_s;
              col_out   <= col_drive(col_next_s);
            end
          end
          ST_DEBOUNCE: begin
            if (!sel_row_s) begin
              if (cnt_inc_s == CNT_DONE) begin
                key_code  <= {row_idx_r, col_idx_r};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt_r     <= {CNT_W{1'b0}};
                state_r   <= ST_HELD;
              end else begin
                cnt_r <= cnt_inc_s;
              end
            end else begin
              cnt_r   <= {CNT_W{1'b0}};
              state_r <= ST_SCAN;
            end
          end
          ST_HELD: begin
            // Count consecutive released ticks; any low reading restarts the count.
            if (sel_row_s) begin
              if (cnt_inc_s == CNT_DONE) begin
                key_held <= 1'b0;
                cnt_r    <= {CNT_W{1'b0}};
                state_r  <= ST_SCAN;
              end else begin
                cnt_r <= cnt_inc_s;
              end
            end else begin
              cnt_r <= {CNT_W{1'b0}};
            end
          end
          default: begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix driven by a set of pressed keys and a
// tick-level reference model of the scan/debounce rules, checked every clock.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DT       = 3;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;   // bit r*4+c set = key at row r, column c is pressed

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc    = 0;

  // reference model state, advanced once per scan tick
  int   m_col, m_mode, m_row, m_cnt;   // mode: 0 idle, 1 confirming, 2 locked
  logic [3:0] m_code;
  logic m_valid, m_held;
  logic tick_seen;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // physical matrix: a row reads low when a pressed key sits on a driven column
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pressed(input int r, input int c);
    return keys[r*4+c];
  endfunction

  task automatic model_reset();
    m_col = 0; m_mode = 0; m_row = 0; m_cnt = 0;
    m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0;
    cyc = 0;
  endtask

  task automatic accept();
    m_code  = 4'(m_row*4 + m_col);
    m_valid = 1'b1;
    m_held  = 1'b1;
    m_cnt   = 0;
    m_mode  = 2;
  endtask

  task automatic model_tick();
    int low;
    low = -1;
    for (int r = 3; r >= 0; r--) if (pressed(r, m_col)) low = r;
    case (m_mode)
      0: if (low >= 0) begin
           m_row = low; m_cnt = 1;
           if (DT == 1) accept(); else m_mode = 1;
         end else m_col = (m_col + 1) % 4;
      1: if (pressed(m_row, m_col)) begin
           m_cnt++;
           if (m_cnt == DT) accept();
         end else begin
           m_cnt = 0; m_mode = 0;
         end
      default: if (!pressed(m_row, m_col)) begin
           m_cnt++;
           if (m_cnt == DT) begin m_held = 1'b0; m_cnt = 0; m_mode = 0; end
         end else m_cnt = 0;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    m_valid   = 1'b0;
    tick_seen = (cyc % SCAN_DIV == SCAN_DIV - 1);
    if (tick_seen) model_tick();
    cyc++;
    @(negedge clk);
    if (key_valid) pulses++;
    check("col_out", 32'(col_out), 32'(~(4'b0001 << m_col) & 4'hF));
    check("key_code", 32'(key_code), 32'(m_code));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_held", 32'(key_held), 32'(m_held));
  endtask

  task automatic run_ticks(input int n);
    int t;
    t = 0;
    while (t < n) begin
      step();
      if (tick_seen) t++;
    end
  endtask

  task automatic wait_mode(input int target, input string tag);
    int n;
    n = 0;
    while (m_mode != target && n < 40) begin
      run_ticks(1);
      n++;
    end
    check({"timeout_", tag}, 32'(m_mode), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_col_out", 32'(col_out), 32'h0000000E);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b1;
    keys = 16'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    // idle scanning through all columns twice
    run_ticks(8);

    // key 9: row 2, column 1
    keys = 16'h0200;
    pulses = 0;
    wait_mode(2, "accept9");
    check("key9_code", 32'(key_code), 32'h9);
    check("key9_held", 32'(key_held), 32'h1);
    check("key9_col", 32'(col_out), 32'hD);
    check("key9_pulses", 32'(pulses), 32'h1);
    run_ticks(3);
    check("key9_col_frozen", 32'(col_out), 32'hD);

    // release: held drops, then scanning resumes at the next column
    keys = 16'h0;
    wait_mode(0, "release9");
    check("rel9_held", 32'(key_held), 32'h0);
    check("rel9_code", 32'(key_code), 32'h9);
    run_ticks(1);
    check("rel9_resume_col", 32'(col_out), 32'hB);

    // bounce: a short low, high, low again must never be accepted
    pulses = 0;
    keys = 16'h0020;
    wait_mode(1, "bounce_a");
    keys = 16'h0;
    run_ticks(1);
    keys = 16'h0020;
    wait_mode(1, "bounce_b");
    keys = 16'h0;
    run_ticks(6);
    check("bounce_pulses", 32'(pulses), 32'h0);
    check("bounce_code", 32'(key_code), 32'h9);

    // rows 0 and 3 on column 2: lowest row wins; extra key during hold is ignored
    keys = 16'h4004;
    wait_mode(2, "dual");
    check("dual_code", 32'(key_code), 32'h2);
    keys = 16'h4014;
    run_ticks(6);
    check("dual_ignore_code", 32'(key_code), 32'h2);
    check("dual_ignore_col", 32'(col_out), 32'hB);
    keys = 16'h0;
    wait_mode(0, "dual_rel");

    // reset while confirming, then a full re-debounce with the key still down
    keys = 16'h0200;
    wait_mode(1, "rst_deb");
    do_reset();
    pulses = 0;
    wait_mode(2, "rst_deb_re");
    check("rst_deb_code", 32'(key_code), 32'h9);
    check("rst_deb_pulses", 32'(pulses), 32'h1);

    // reset while held
    do_reset();
    run_ticks(1);
    check("rst_held_held", 32'(key_held), 32'h0);
    wait_mode(2, "rst_held_re");
    keys = 16'h0;
    wait_mode(0, "rst_held_rel");

    // randomized key activity
    for (int i = 0; i < 250; i++) begin
      keys = 16'h0;
      for (int k = $urandom_range(0, 2); k > 0; k--) keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 39) == 0) do_reset();
      run_ticks($urandom_range(1, 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
